// File: rtl/flappy_game_ctrl_if.sv
// Signal bundle between the frame/physics side of the game and its controller.
// The master drives frame timing and playfield geometry; the slave reports game status.
interface flappy_game_ctrl_if;
  logic        frame_tick;
  logic        flap_req;
  logic [9:0]  bird_y;
  logic [29:0] pipe_x;
  logic [29:0] gap_top;
  logic [29:0] gap_bottom;
  logic [1:0]  state;
  logic        run_en;
  logic        flap_go;
  logic        restart;
  logic        hit;
  logic [11:0] score_bcd;
  logic        irq;

  modport master (
    output frame_tick, flap_req, bird_y, pipe_x, gap_top, gap_bottom,
    input  state, run_en, flap_go, restart, hit, score_bcd, irq
  );

  modport slave (
    input  frame_tick, flap_req, bird_y, pipe_x, gap_top, gap_bottom,
    output state, run_en, flap_go, restart, hit, score_bcd, irq
  );
endinterface

// File: rtl/flappy_game_ctrl.sv
// Game state machine for a Flappy-style game: collision, BCD scoring, death delay and restart.
// Evaluates once per frame_tick; between ticks it only remembers a pending flap.
module flappy_game_ctrl #(
  parameter int BIRD_X       = 100,
  parameter int BIRD_WIDTH   = 34,
  parameter int BIRD_HEIGHT  = 24,
  parameter int PIPE_WIDTH   = 70,
  parameter int FLOOR_Y      = 456,
  parameter int DEATH_FRAMES = 60
) (
  input  logic               clk,
  input  logic               reset,
  flappy_game_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    DYING = 2'd2,
    OVER  = 2'd3
  } state_e;

  localparam int CNT_W = (DEATH_FRAMES > 1) ? $clog2(DEATH_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEATH_FRAMES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Geometry is compared at 11 bits so a pipe near column 1023 plus its width cannot wrap.
  localparam logic [10:0] BIRD_LEFT  = 11'(BIRD_X);
  localparam logic [10:0] BIRD_RIGHT = 11'(BIRD_X + BIRD_WIDTH);
  localparam logic [10:0] PIPE_W     = 11'(PIPE_WIDTH);
  localparam logic [10:0] BIRD_H_M1  = 11'(BIRD_HEIGHT - 1);
  localparam logic [10:0] FLOOR_ROW  = 11'(FLOOR_Y);

  state_e           state_q, state_d;
  logic             run_en_q, run_en_d;
  logic             flap_go_q, flap_go_d;
  logic             restart_q, restart_d;
  logic             hit_q, hit_d;
  logic [11:0]      score_q, score_d;
  logic             irq_q, irq_d;
  logic             flap_pend_q, flap_pend_d;
  logic [2:0]       passed_q, passed_d;
  logic [CNT_W-1:0] death_cnt_q, death_cnt_d;

  logic [10:0] px [3];
  logic [10:0] top [3];
  logic [10:0] bot [3];
  logic [10:0] y_top, y_bot;
  logic        collide;
  logic [2:0]  pass, wrap;
  logic        flap_now;

  // One-point BCD increment that sticks at 999.
  function automatic logic [11:0] bcd_inc(input logic [11:0] s);
    logic [11:0] r;
    r = s;
    if (s == 12'h999) return s;
    if (r[3:0] == 4'd9) begin
      r[3:0] = 4'd0;
      if (r[7:4] == 4'd9) begin
        r[7:4]  = 4'd0;
        r[11:8] = r[11:8] + 4'd1;
      end else begin
        r[7:4] = r[7:4] + 4'd1;
      end
    end else begin
      r[3:0] = r[3:0] + 4'd1;
    end
    return r;
  endfunction

  // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    collide = 1'b0;
    pass    = '0;
    wrap    = '0;
    y_top   = {1'b0, bus.bird_y};
    y_bot   = y_top + BIRD_H_M1;
    for (int i = 0; i < 3; i++) begin
      px[i]  = {1'b0, bus.pipe_x[i*10 +: 10]};
      top[i] = {1'b0, bus.gap_top[i*10 +: 10]};
      bot[i] = {1'b0, bus.gap_bottom[i*10 +: 10]};
      if ((BIRD_LEFT < px[i] + PIPE_W) && (px[i] < BIRD_RIGHT) &&
          ((y_top < top[i]) || (y_bot > bot[i])))
        collide = 1'b1;
      pass[i] = (px[i] + PIPE_W < BIRD_LEFT) && !passed_q[i];
      wrap[i] = (px[i] > BIRD_RIGHT);
    end
    if (y_top >= FLOOR_ROW) collide = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    flap_now    = flap_pend_q | bus.flap_req;
    flap_pend_d = flap_now;
    flap_go_d   = 1'b0;
    restart_d   = 1'b0;
    hit_d       = hit_q;
    score_d     = score_q;
    passed_d    = passed_q;
    death_cnt_d = death_cnt_q;

    if (bus.frame_tick) begin
      // A tick always consumes the pending flap, including one arriving this very cycle.
      flap_pend_d = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (flap_now) begin
            state_d   = PLAY;
            flap_go_d = 1'b1;
            score_d   = '0;
            passed_d  = '0;
          end
        end
        PLAY: begin
          if (collide) begin
            state_d     = DYING;
            hit_d       = 1'b1;
            death_cnt_d = '0;
          end else begin
            flap_go_d = flap_now;
            for (int i = 0; i < 3; i++) begin
              if (pass[i]) begin
                score_d     = bcd_inc(score_d);
                passed_d[i] = 1'b1;
              end else if (wrap[i]) begin
                passed_d[i] = 1'b0;
              end
            end
          end
        end
        DYING: begin
          if (death_cnt_q == CNT_LAST) state_d = OVER;
          else                         death_cnt_d = death_cnt_q + CNT_ONE;
        end
        OVER: begin
          if (flap_now) begin
            state_d   = IDLE;
            restart_d = 1'b1;
            hit_d     = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    run_en_d = (state_d == PLAY);
    irq_d    = (state_d == OVER);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      run_en_q    <= 1'b0;
      flap_go_q   <= 1'b0;
      restart_q   <= 1'b0;
      hit_q       <= 1'b0;
      score_q     <= '0;
      irq_q       <= 1'b0;
      flap_pend_q <= 1'b0;
      passed_q    <= '0;
      death_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      run_en_q    <= run_en_d;
      flap_go_q   <= flap_go_d;
      restart_q   <= restart_d;
      hit_q       <= hit_d;
      score_q     <= score_d;
      irq_q       <= irq_d;
      flap_pend_q <= flap_pend_d;
      passed_q    <= passed_d;
      death_cnt_q <= death_cnt_d;
    end
  end

  assign bus.state     = state_q;
  assign bus.run_en    = run_en_q;
  assign bus.flap_go   = flap_go_q;
  assign bus.restart   = restart_q;
  assign bus.hit       = hit_q;
  assign bus.score_bcd = score_q;
  assign bus.irq       = irq_q;

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// Directed bench for flappy_game_ctrl: start, scoring, collision, death delay, restart, reset.
module tb_flappy_game_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  flappy_game_ctrl_if bus ();

  flappy_game_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input logic flap);
    bus.frame_tick = 1'b1;
    bus.flap_req   = flap;
    cycle();
    bus.frame_tick = 1'b0;
    bus.flap_req   = 1'b0;
  endtask

  task automatic pulse_flap();
    bus.flap_req = 1'b1;
    cycle();
    bus.flap_req = 1'b0;
  endtask

  task automatic set_pipes(input logic [9:0] p1, input logic [9:0] p2, input logic [9:0] p3);
    bus.pipe_x = {p3, p2, p1};
  endtask

  // Wrap every pipe behind the bird, then bring the chosen ones past it.
  task automatic score_round(input logic [9:0] p1, input logic [9:0] p2, input logic [9:0] p3);
    set_pipes(10'd900, 10'd900, 10'd900);
    tick(1'b0);
    set_pipes(p1, p2, p3);
    tick(1'b0);
  endtask

  initial begin
    reset          = 1'b1;
    bus.frame_tick = 1'b0;
    bus.flap_req   = 1'b0;
    bus.bird_y     = 10'd200;
    set_pipes(10'd900, 10'd900, 10'd900);
    bus.gap_top    = '0;
    bus.gap_bottom = {10'd479, 10'd479, 10'd479};
    repeat (3) cycle();
    reset = 1'b0;

    check("rst_state",   32'(bus.state),     32'd0);
    check("rst_run_en",  32'(bus.run_en),    32'd0);
    check("rst_flap_go", 32'(bus.flap_go),   32'd0);
    check("rst_restart", 32'(bus.restart),   32'd0);
    check("rst_hit",     32'(bus.hit),       32'd0);
    check("rst_score",   32'(bus.score_bcd), 32'h000);
    check("rst_irq",     32'(bus.irq),       32'd0);

    tick(1'b0);
    check("idle_no_flap", 32'(bus.state), 32'd0);

    // Flap latched between ticks starts the game on the next tick.
    pulse_flap();
    cycle();
    check("idle_wait", 32'(bus.state), 32'd0);
    tick(1'b0);
    check("start_state",   32'(bus.state),     32'd1);
    check("start_flap_go", 32'(bus.flap_go),   32'd1);
    check("start_run_en",  32'(bus.run_en),    32'd1);
    check("start_score",   32'(bus.score_bcd), 32'h000);
    cycle();
    check("flap_go_1cyc", 32'(bus.flap_go), 32'd0);

    set_pipes(10'd20, 10'd900, 10'd900);
    tick(1'b0);
    check("pass1_score", 32'(bus.score_bcd), 32'h001);
    set_pipes(10'd18, 10'd900, 10'd900);
    tick(1'b0);
    check("pass1_once_a", 32'(bus.score_bcd), 32'h001);
    tick(1'b0);
    check("pass1_once_b", 32'(bus.score_bcd), 32'h001);

    set_pipes(10'd900, 10'd900, 10'd900);
    tick(1'b0);
    set_pipes(10'd30, 10'd900, 10'd900);
    tick(1'b0);
    check("pass_edge_30", 32'(bus.score_bcd), 32'h001);
    set_pipes(10'd29, 10'd900, 10'd900);
    tick(1'b0);
    check("pass_edge_29", 32'(bus.score_bcd), 32'h002);

    tick(1'b1);
    check("play_flap_go", 32'(bus.flap_go),   32'd1);
    check("play_flap_sc", 32'(bus.score_bcd), 32'h002);

    // Pipe 2 touching the bird's right edge exactly does not overlap.
    bus.bird_y  = 10'd50;
    bus.gap_top = {10'd0, 10'd100, 10'd0};
    set_pipes(10'd29, 10'd134, 10'd900);
    tick(1'b0);
    check("edge_134_play", 32'(bus.state), 32'd1);

    bus.gap_top = {10'd100, 10'd100, 10'd100};
    set_pipes(10'd110, 10'd900, 10'd900);
    tick(1'b1);
    check("hit_state",   32'(bus.state),     32'd2);
    check("hit_flag",    32'(bus.hit),       32'd1);
    check("hit_flap_go", 32'(bus.flap_go),   32'd0);
    check("hit_run_en",  32'(bus.run_en),    32'd0);
    check("hit_score",   32'(bus.score_bcd), 32'h002);

    for (int k = 1; k <= 59; k++) begin
      tick(k == 10);
      if (k == 10) check("dying_flap_go", 32'(bus.flap_go), 32'd0);
    end
    check("dying_59_state", 32'(bus.state), 32'd2);
    check("dying_59_irq",   32'(bus.irq),   32'd0);
    pulse_flap();
    tick(1'b0);
    check("over_state", 32'(bus.state), 32'd3);
    check("over_irq",   32'(bus.irq),   32'd1);
    tick(1'b0);
    check("over_hold_state",   32'(bus.state),     32'd3);
    check("over_hold_restart", 32'(bus.restart),   32'd0);
    check("over_hold_score",   32'(bus.score_bcd), 32'h002);

    tick(1'b1);
    check("restart_pulse",   32'(bus.restart), 32'd1);
    check("restart_state",   32'(bus.state),   32'd0);
    check("restart_hit",     32'(bus.hit),     32'd0);
    check("restart_irq",     32'(bus.irq),     32'd0);
    check("restart_flap_go", 32'(bus.flap_go), 32'd0);
    cycle();
    check("restart_1cyc", 32'(bus.restart), 32'd0);

    // Score pump: three pipes pass per round.
    bus.bird_y  = 10'd200;
    bus.gap_top = '0;
    set_pipes(10'd900, 10'd900, 10'd900);
    tick(1'b1);
    check("game2_score", 32'(bus.score_bcd), 32'h000);
    for (int r = 1; r <= 332; r++) begin
      score_round(10'd20, 10'd20, 10'd20);
      if (r == 3)  check("bcd_009", 32'(bus.score_bcd), 32'h009);
      if (r == 4)  check("bcd_012", 32'(bus.score_bcd), 32'h012);
      if (r == 33) check("bcd_099", 32'(bus.score_bcd), 32'h099);
      if (r == 34) check("bcd_102", 32'(bus.score_bcd), 32'h102);
    end
    check("bcd_996", 32'(bus.score_bcd), 32'h996);
    score_round(10'd20, 10'd20, 10'd900);
    check("bcd_998", 32'(bus.score_bcd), 32'h998);
    score_round(10'd20, 10'd20, 10'd900);
    check("sat_999", 32'(bus.score_bcd), 32'h999);
    score_round(10'd20, 10'd20, 10'd20);
    check("sat_hold", 32'(bus.score_bcd), 32'h999);

    set_pipes(10'd900, 10'd900, 10'd900);
    bus.bird_y = 10'd455;
    tick(1'b0);
    check("floor_455", 32'(bus.state), 32'd1);
    bus.bird_y = 10'd456;
    tick(1'b0);
    check("floor_456", 32'(bus.state), 32'd2);
    check("floor_hit", 32'(bus.hit),   32'd1);
    repeat (60) tick(1'b0);
    check("over2_state", 32'(bus.state),     32'd3);
    check("over2_irq",   32'(bus.irq),       32'd1);
    check("over2_score", 32'(bus.score_bcd), 32'h999);
    tick(1'b1);
    check("restart2_pulse", 32'(bus.restart), 32'd1);
    check("restart2_state", 32'(bus.state),   32'd0);
    check("restart2_hit",   32'(bus.hit),     32'd0);

    // Reset mid-game discards both the tick in flight and the pending flap.
    bus.bird_y = 10'd200;
    tick(1'b1);
    check("game3_state", 32'(bus.state), 32'd1);
    pulse_flap();
    reset          = 1'b1;
    bus.frame_tick = 1'b1;
    bus.flap_req   = 1'b1;
    cycle();
    reset          = 1'b0;
    bus.frame_tick = 1'b0;
    bus.flap_req   = 1'b0;
    check("midrst_state",  32'(bus.state),     32'd0);
    check("midrst_run_en", 32'(bus.run_en),    32'd0);
    check("midrst_score",  32'(bus.score_bcd), 32'h000);
    tick(1'b0);
    check("midrst_no_pend",    32'(bus.state),   32'd0);
    check("midrst_no_flap_go", 32'(bus.flap_go), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/flappy_game_ctrl.md
FLAPPY_GAME_CTRL -- requirements
Module: flappy_game_ctrl

Interface
REQ-001 Parameter BIRD_X, default 100, bird left column in pixels.
REQ-002 Parameter BIRD_WIDTH, default 34, bird width in pixels.
REQ-003 Parameter BIRD_HEIGHT, default 24, bird height in pixels.
REQ-004 Parameter PIPE_WIDTH, default 70, pipe width in pixels.
REQ-005 Parameter FLOOR_Y, default 456, bird_y at or above this value is a floor hit.
REQ-006 Parameter DEATH_FRAMES, default 60, number of frames spent in DYING.
REQ-007 clk  input  1  system clock (50 MHz); one clock, no other clock domains.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 frame_tick  input  1  one-cycle pulse per frame, on the rising edge of vertical sync.
REQ-010 flap_req  input  1  one-cycle pulse from an Avalon write to the FLAP register.
REQ-011 bird_y  input  10  current bird top row.
REQ-012 pipe_x  input  30  {pipe3_x, pipe2_x, pipe1_x}, left column of each pipe.
REQ-013 gap_top  input  30  {p3, p2, p1}, first open row of each gap.
REQ-014 gap_bottom  input  30  {p3, p2, p1}, last open row of each gap.
REQ-015 state  output  2  IDLE=0, PLAY=1, DYING=2, OVER=3.
REQ-016 run_en  output  1  high only in PLAY; it gates the bird physics and pipe motion.
REQ-017 flap_go  output  1  one-cycle flap command to the bird physics.
REQ-018 restart  output  1  one-cycle pulse that commands the bird and pipe logic to reinitialise.
REQ-019 hit  output  1  sticky collision flag.
REQ-020 score_bcd  output  12  three BCD digits, hundreds in [11:8].
REQ-021 irq  output  1  level signal, high while in OVER.

Function
REQ-022 All outputs are registered and update on the clk edge after the frame_tick cycle that causes the change.
REQ-023 flap_pend is set by flap_req and cleared when a frame_tick consumes it.
- A flap_req that arrives in the same cycle as frame_tick is consumed by that tick.
REQ-024 State evaluation and transitions occur only in cycles where frame_tick=1; all other cycles only latch flap_req.
REQ-025 IDLE, on a tick with flap pending:
- go to PLAY;
- pulse flap_go;
- clear score_bcd and all passed flags.
REQ-026 PLAY collision test for pipe i:
- horizontal overlap: BIRD_X < px_i+PIPE_WIDTH and px_i < BIRD_X+BIRD_WIDTH;
- vertical: bird_y < top_i or bird_y+BIRD_HEIGHT-1 > bottom_i.
REQ-027 All sums in the collision and scoring tests SHALL be computed at 11 bits, so pipe_x values up to 1023 do not wrap.
REQ-028 PLAY, on a tick where any pipe collides or bird_y >= FLOOR_Y:
- go to DYING and set hit=1;
- no flap_go and no score increment on that tick.
REQ-029 PLAY, on a tick with no collision:
- flap pending -> pulse flap_go;
- for each pipe with px_i+PIPE_WIDTH < BIRD_X and passed_i=0, increment score once and set passed_i;
- clear passed_i when px_i > BIRD_X+BIRD_WIDTH (pipe wrapped).
REQ-030 Score increments by up to 3 on one tick with correct BCD carry, and saturates at 999.
REQ-031 DYING:
- death_cnt counts ticks from 0 and at DEATH_FRAMES-1 moves to OVER;
- flaps are discarded and flap_pend is cleared on every tick.
REQ-032 OVER:
- irq=1 and score is held;
- on a tick with flap pending, pulse restart, clear hit, go to IDLE; no flap_go is produced.
REQ-033 flap_go and restart are never high in the same cycle and never last longer than one cycle.

Reset
REQ-034 Reset values:
- state=IDLE, run_en=0, flap_go=0, restart=0;
- hit=0, score_bcd=0, irq=0;
- flap_pend=0, passed=0, death_cnt=0.
REQ-035 Reset asserted mid-game returns to IDLE on the next edge and discards any pending flap and any in-progress tick evaluation.

Verification
REQ-036 IDLE, flap_req, then a tick -> state=PLAY, flap_go high for exactly 1 cycle, score=000.
REQ-037 PLAY with pipe1_x=20 (others 900), passed1=0, no collision, tick -> score=001; further ticks with pipe1_x=18 leave the score at 001.
REQ-038 PLAY with pipe1_x=110, bird_y=50, gap_top=100, plus a flap_req in the same cycle as the tick -> DYING, hit=1, flap_go=0.
REQ-039 Enter DYING, apply 60 ticks -> OVER and irq=1 exactly after the 60th tick; a flap_req during DYING is ignored.
REQ-040 Score 998, a tick where two pipes pass -> 999 (saturated); then OVER, flap_req + tick -> restart pulse, IDLE, hit=0.
